// File: rtl/stomp_detector.sv
// stomp_detector: per-frame judge of one character landing on the other's head.
// STOMP_COOLDOWN_EN selects per-victim cooldown counters; without it each direction fires once per rising condition.
module stomp_detector #(
  parameter int POS_W           = 10,
  parameter int CHAR_W          = 16,
  parameter int CHAR_H          = 16,
  parameter int HEAD_BAND       = 4,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             game_active,
  input  logic [POS_W-1:0] c1_x,
  input  logic [POS_W-1:0] c1_y,
  input  logic [POS_W-1:0] c2_x,
  input  logic [POS_W-1:0] c2_y,
  output logic             character1_stepped,
  output logic             character2_stepped,
  output logic             c1_invuln,
  output logic             c2_invuln
);
  localparam int W = POS_W + 1;
  if (COOLDOWN_FRAMES < 1) begin : g_bad_cooldown
    $error("COOLDOWN_FRAMES must be at least 1");
  end
  logic [POS_W-1:0] c1_y_prev, c2_y_prev;
  logic prev_valid;
  logic [W-1:0] x1, y1, x2, y2, dx, feet1, feet2;
  logic fall1, fall2, hit12, hit21, fire1, fire2;
  assign x1 = W'(c1_x);
  assign y1 = W'(c1_y);
  assign x2 = W'(c2_x);
  assign y2 = W'(c2_y);
  assign dx = x1 > x2 ? x1 - x2 : x2 - x1;
  assign feet1 = y1 + W'(CHAR_H);
  assign feet2 = y2 + W'(CHAR_H);
  assign fall1 = prev_valid && (c1_y > c1_y_prev);
  assign fall2 = prev_valid && (c2_y > c2_y_prev);
  assign hit12 = fall1 && (dx < W'(CHAR_W)) && (y2 <= feet1) && (feet1 <= y2 + W'(HEAD_BAND));
  assign hit21 = fall2 && (dx < W'(CHAR_W)) && (y1 <= feet2) && (feet2 <= y1 + W'(HEAD_BAND));
`ifdef STOMP_COOLDOWN_EN
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  logic [CW-1:0] cnt1, cnt2;
  assign fire1 = hit12 && !hit21 && (cnt2 == '0);
  assign fire2 = hit21 && !hit12 && (cnt1 == '0);
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (!game_active) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      cnt1 <= fire2 ? CW'(COOLDOWN_FRAMES) : (cnt1 != '0 ? cnt1 - 1'b1 : cnt1);
      cnt2 <= fire1 ? CW'(COOLDOWN_FRAMES) : (cnt2 != '0 ? cnt2 - 1'b1 : cnt2);
    end
  end
  assign c1_invuln = cnt1 != '0;
  assign c2_invuln = cnt2 != '0;
`else
  logic hit12_q, hit21_q;
  assign fire1 = hit12 && !hit21 && !hit12_q;
  assign fire2 = hit21 && !hit12 && !hit21_q;
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      hit12_q <= 1'b0;
      hit21_q <= 1'b0;
    end else begin
      hit12_q <= game_active && hit12;
      hit21_q <= game_active && hit21;
    end
  end
  assign c1_invuln = 1'b0;
  assign c2_invuln = 1'b0;
`endif
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      c1_y_prev          <= '0;
      c2_y_prev          <= '0;
      prev_valid         <= 1'b0;
      character1_stepped <= 1'b0;
      character2_stepped <= 1'b0;
    end else begin
      c1_y_prev          <= c1_y;
      c2_y_prev          <= c2_y;
      prev_valid         <= game_active;
      character1_stepped <= game_active && fire1;
      character2_stepped <= game_active && fire2;
    end
  end
endmodule

// File: doc/stomp_detector.md
# stomp_detector

Per-frame collision judge between the two player characters. Each `frame_clk` it compares both characters' hitboxes and decides whether one has landed on the other's head. It emits one-frame `character1_stepped` / `character2_stepped` pulses that feed `game_fsm`, which decrements the victim's lives. It also applies a per-victim invulnerability window so that a single stomp costs exactly one life.

## Interface
Parameters:
- `POS_W`, 10: width of position coordinates (pixels, origin top-left, y grows downward).
- `CHAR_W`, 16: hitbox width in pixels.
- `CHAR_H`, 16: hitbox height in pixels.
- `HEAD_BAND`, 4: depth of the stompable head region, in pixels below the victim's top edge.
- `COOLDOWN_FRAMES`, 60: victim invulnerability length in frames, ≥1.

Ports:
- `frame_clk`, in, 1: only clock; one edge per video frame.
- `Reset`, in, 1: asynchronous, active-high.
- `game_active`, in, 1: high while `game_fsm` is in PLAYING.
- `c1_x`, `c1_y`, in, POS_W each: character 1 top-left corner.
- `c2_x`, `c2_y`, in, POS_W each: character 2 top-left corner.
- `character1_stepped`, out, 1: pulse meaning character 1 stomped character 2.
- `character2_stepped`, out, 1: pulse meaning character 2 stomped character 1.
- `c1_invuln`, `c2_invuln`, out, 1: the character is in its cooldown window (used by the sprite blinker).

## Operation
- Registers:
  - `c1_y_prev`, `c2_y_prev` hold the y value sampled on the previous edge.
  - `prev_valid` is cleared by Reset and while `game_active`=0, and set on the first active edge.
- Falling test for A: `prev_valid` && `A_y > A_y_prev`.
- Stomp condition A-on-B, all terms true:
  - A is falling;
  - |A_x − B_x| < CHAR_W;
  - B_y ≤ A_y + CHAR_H ≤ B_y + HEAD_BAND.
- Arithmetic: all sums and differences are computed at POS_W+1 bits unsigned. The absolute difference uses the larger operand minus the smaller. Nothing wraps.
- Victim state per character, held as a cooldown counter of width `$clog2(COOLDOWN_FRAMES+1)`:
  - ARMED: counter = 0.
  - COOLDOWN: counter ≠ 0.
- When A-on-B is true and B is ARMED:
  - the A-stepped pulse is registered high;
  - B's counter loads COOLDOWN_FRAMES.
- Conditions against a victim in COOLDOWN are ignored.
- Simultaneous events:
  - Both A-on-B and B-on-A true on the same edge: neither pulse fires and neither counter loads (a tie).
  - Only one direction is true: that direction is processed independently of the other character's cooldown state.
- `game_active`=0: both pulses are forced 0, both counters cleared, `prev_valid` cleared. The y_prev registers still track their inputs.

## Timing
- Reset values: both pulses 0, both invuln outputs 0, counters 0, `prev_valid` 0, y_prev registers 0.
- Latency: positions sampled at edge N produce the pulse during the cycle after edge N. Each pulse is exactly 1 cycle wide.
- The first active edge after Reset or after `game_active` rises never produces a stomp, because `prev_valid` is 0.
- Cooldown timing:
  - The counter loads on the pulse edge and decrements on each later edge.
  - `cN_invuln` = (counter ≠ 0) is high for exactly COOLDOWN_FRAMES cycles, starting in the pulse cycle.
  - The minimum spacing between pulses against the same victim is COOLDOWN_FRAMES+1 frames.
- Reset asserted mid-cooldown: all state clears immediately, without waiting for a clock edge.

## Configuration
- `STOMP_COOLDOWN_EN` defined: cooldown counters and invuln outputs are implemented as described above.
- `STOMP_COOLDOWN_EN` undefined:
  - Counters are removed and `c1_invuln` / `c2_invuln` are tied to 0.
  - Each direction instead fires only on the rising edge of its stomp condition: the condition must be false on at least one edge before it can pulse again.
  - Tie rule and `game_active` rule are unchanged.

## Test plan
All scenarios use default parameters except where a value is given.
- Reset: assert Reset with arbitrary inputs → all outputs 0 within the same cycle, with no clock required.
- Basic stomp:
  - stimulus: `game_active`=1; c2 = (105,96); c1 moves (100,78) → (100,80);
  - response: c1 feet at 96, inside [96,100]; dx = 5 → `character1_stepped`=1 for one cycle; `c2_invuln` high for 60 cycles.
- Rejects: the same setup with c1_y held at 80 (not falling), or with c1_x = 121 (dx = 16) → no pulse.
- Cooldown (COOLDOWN_FRAMES=4): keep the stomp condition true on every edge → pulses at frames 0, 5, 10; `c2_invuln` high 4 cycles after each pulse.
- Tie: CHAR_H=16, HEAD_BAND=32, both characters falling at the same x with overlapping heads → no pulse and no invuln.
- Drop `game_active` mid-cooldown → invuln clears on the next edge. Re-raise it → no stomp on the first edge, even though the condition is true.
